// File: rtl/rv_core_pkg.sv
// Shared RV32 core definitions: default data width, register index width,
// the hardwired-zero register index and the register address type.
package rv_core_pkg;

    localparam int RV_XLEN    = 32;
    localparam int REG_ADDR_W = 5;
    localparam int X0         = 0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Bundle of the register file read, writeback, issue and debug signals.
// master: issue/writeback/debug side driving the file; slave: the register file.
interface regfile_sb_if
    import rv_core_pkg::*;
#(
    parameter int XLEN  = RV_XLEN,
    parameter int NREGS = 2 ** REG_ADDR_W
) ();

    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            wb_we;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;
    logic [AW:0]     pend_cnt;

    modport master (
        output rs1_addr, rs2_addr, wb_we, wb_addr, wb_data,
               issue_valid, issue_rd, dbg_addr,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, dbg_data, pend_cnt
    );

    modport slave (
        input  rs1_addr, rs2_addr, wb_we, wb_addr, wb_data,
               issue_valid, issue_rd, dbg_addr,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, dbg_data, pend_cnt
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at
// writeback, with set winning when both hit the same register in one cycle.
// pend_cnt is the registered popcount of the bits, updated with them.
module regfile_scoreboard #(
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    input  logic             wb_we,
    input  logic [AW-1:0]    wb_addr,
    output logic [NREGS-1:0] pend,
    output logic [AW:0]      pend_cnt
);

    logic [NREGS-1:0] pend_r;
    logic [NREGS-1:0] pend_nxt_s;
    logic [AW:0]      cnt_r;

    function automatic logic [AW:0] popcount(input logic [NREGS-1:0] bits);
        logic [AW:0] acc;
        acc = {(AW+1){1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            acc = acc + {{AW{1'b0}}, bits[i]};
        end
        return acc;
    endfunction

    // Next pending state: a new producer supersedes a completing one; x0 never pends.
    always_comb begin
        pend_nxt_s = pend_r;
        for (int i = 1; i < NREGS; i++) begin
            if (issue_valid && (issue_rd == AW'(i))) begin
                pend_nxt_s[i] = 1'b1;
            end else if (wb_we && (wb_addr == AW'(i))) begin
                pend_nxt_s[i] = 1'b0;
            end else begin
                pend_nxt_s[i] = pend_r[i];
            end
        end
        pend_nxt_s[0] = 1'b0;
    end

    // Pending bits and their count; reset discards any same-cycle issue/writeback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_r <= {NREGS{1'b0}};
            cnt_r  <= {(AW+1){1'b0}};
        end else begin
            pend_r <= pend_nxt_s;
            cnt_r  <= popcount(pend_nxt_s);
        end
    end

    assign pend     = pend_r;
    assign pend_cnt = cnt_r;

endmodule

// File: rtl/regfile_sb.sv
// RV32 integer register file with pending-write scoreboard.
// Two combinational read ports, one synchronous write port, one debug port;
// x0 reads as zero and never pends.
// Build option: define REGFILE_BYPASS_EN to forward the writeback data to a
// matching read port in the same cycle (debug port is never forwarded).
module regfile_sb
    import rv_core_pkg::*;
#(
    parameter int XLEN  = RV_XLEN,
    parameter int NREGS = 2 ** REG_ADDR_W
) (
    input logic         clk,
    input logic         reset,
    regfile_sb_if.slave bus
);

    localparam int            AW        = $clog2(NREGS);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(X0);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [XLEN-1:0]  regs_r [NREGS];
    logic [NREGS-1:0] pend_s;
    logic [AW:0]      pend_cnt_s;
    logic             wb_ok_s;
    logic             issue_on_wb_s;
    logic [XLEN:0]    rs1_rd_s;
    logic [XLEN:0]    rs2_rd_s;

    // Returns {busy, data} for one read port.
    function automatic logic [XLEN:0] read_port(
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] arr_data,
        input logic            arr_busy,
        input logic            fwd_hit,
        input logic [XLEN-1:0] fwd_data,
        input logic            fwd_reissue
    );
        logic [XLEN:0] res;
        if (addr == ZERO_ADDR) begin
            res = {1'b0, {XLEN{1'b0}}};
        end else if (fwd_hit) begin
            // Forwarded value is complete unless a new producer reissues the register.
            res = {(fwd_reissue & arr_busy), fwd_data};
        end else begin
            res = {arr_busy, arr_data};
        end
        return res;
    endfunction

    assign wb_ok_s       = bus.wb_we && (bus.wb_addr != ZERO_ADDR);
    assign issue_on_wb_s = bus.issue_valid && (bus.issue_rd == bus.wb_addr);

    regfile_scoreboard #(.NREGS(NREGS)) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (bus.issue_valid),
        .issue_rd    (bus.issue_rd),
        .wb_we       (bus.wb_we),
        .wb_addr     (bus.wb_addr),
        .pend        (pend_s),
        .pend_cnt    (pend_cnt_s)
    );

    // Data array: cleared by reset, written at writeback except for x0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wb_ok_s) begin
            regs_r[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Read port muxing with optional same-cycle writeback forwarding.
    always_comb begin
        rs1_rd_s = read_port(bus.rs1_addr, regs_r[bus.rs1_addr], pend_s[bus.rs1_addr],
                             BYPASS && wb_ok_s && (bus.wb_addr == bus.rs1_addr),
                             bus.wb_data, issue_on_wb_s);
        rs2_rd_s = read_port(bus.rs2_addr, regs_r[bus.rs2_addr], pend_s[bus.rs2_addr],
                             BYPASS && wb_ok_s && (bus.wb_addr == bus.rs2_addr),
                             bus.wb_data, issue_on_wb_s);
    end

    // Debug port reads array state only.
    always_comb begin
        if (bus.dbg_addr == ZERO_ADDR) begin
            bus.dbg_data = {XLEN{1'b0}};
        end else begin
            bus.dbg_data = regs_r[bus.dbg_addr];
        end
    end

    assign bus.rs1_data = rs1_rd_s[XLEN-1:0];
    assign bus.rs1_busy = rs1_rd_s[XLEN];
    assign bus.rs2_data = rs2_rd_s[XLEN-1:0];
    assign bus.rs2_busy = rs2_rd_s[XLEN];
    assign bus.pend_cnt = pend_cnt_s;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb. Expected values come from constants and
// a small reference model of the register array and pending bits; they are
// queued when stimulus is applied and compared when outputs are sampled.
module tb_regfile_sb;
    import rv_core_pkg::*;

    localparam int NR = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(32), .NREGS(NR)) bus ();

    regfile_sb #(.XLEN(32), .NREGS(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_reg [NR];
    bit          m_pend [NR];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return bus.rs1_data;
            1:       return bus.rs2_data;
            2:       return {31'd0, bus.rs1_busy};
            3:       return {31'd0, bus.rs2_busy};
            4:       return bus.dbg_data;
            5:       return {26'd0, bus.pend_cnt};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq(e.tag, observe(e.sel), e.exp);
        end
    endtask

    function automatic bit wb_hit(input reg_addr_t a);
        return BYP && bus.wb_we && (bus.wb_addr != 5'd0) && (bus.wb_addr == a);
    endfunction

    function automatic logic [31:0] m_rd(input reg_addr_t a);
        if (a == 5'd0) return 32'd0;
        if (wb_hit(a)) return bus.wb_data;
        return m_reg[a];
    endfunction

    function automatic logic [31:0] m_busy(input reg_addr_t a);
        if (a == 5'd0) return 32'd0;
        if (wb_hit(a) && !(bus.issue_valid && (bus.issue_rd == bus.wb_addr))) return 32'd0;
        return {31'd0, m_pend[a]};
    endfunction

    function automatic logic [31:0] m_cnt();
        int c;
        c = 0;
        for (int i = 0; i < NR; i++) c += int'(m_pend[i]);
        return 32'(c);
    endfunction

    task automatic push_model(input string tag);
        push({tag, ".rs1"},  0, m_rd(bus.rs1_addr));
        push({tag, ".rs2"},  1, m_rd(bus.rs2_addr));
        push({tag, ".b1"},   2, m_busy(bus.rs1_addr));
        push({tag, ".b2"},   3, m_busy(bus.rs2_addr));
        push({tag, ".dbg"},  4, (bus.dbg_addr == 5'd0) ? 32'd0 : m_reg[bus.dbg_addr]);
        push({tag, ".cnt"},  5, m_cnt());
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            m_reg[i]  = 32'd0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic idle();
        bus.rs1_addr    = 5'd0;
        bus.rs2_addr    = 5'd0;
        bus.wb_we       = 1'b0;
        bus.wb_addr     = 5'd0;
        bus.wb_data     = 32'd0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = 5'd0;
        bus.dbg_addr    = 5'd0;
    endtask

    // One clock: model follows the DUT at the rising edge; returns at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            if (bus.wb_we && (bus.wb_addr != 5'd0)) begin
                m_reg[bus.wb_addr]  = bus.wb_data;
                m_pend[bus.wb_addr] = 1'b0;
            end
            if (bus.issue_valid && (bus.issue_rd != 5'd0)) m_pend[bus.issue_rd] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle();
        model_clear();
        #12;
        @(negedge clk);
        reset = 1'b0;

        // Reset state on every address.
        for (int a = 0; a < NR; a++) begin
            bus.rs1_addr = 5'(a);
            bus.rs2_addr = 5'(NR - 1 - a);
            bus.dbg_addr = 5'(a);
            #1;
            push("rst.rs1", 0, 32'd0);
            push("rst.rs2", 1, 32'd0);
            push("rst.b1",  2, 32'd0);
            push("rst.b2",  3, 32'd0);
            push("rst.dbg", 4, 32'd0);
            push("rst.cnt", 5, 32'd0);
            drain();
        end
        @(negedge clk);
        idle();

        // Write x5, read on both ports.
        bus.wb_we = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h0000_152F;
        bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd5;
        #1; push_model("wr5.same"); drain();
        tick();
        bus.wb_we = 1'b0;
        #1;
        push("wr5.rs1", 0, 32'h0000_152F);
        push("wr5.rs2", 1, 32'h0000_152F);
        push_model("wr5.next"); drain();

        // Write to x0 is ignored.
        bus.wb_we = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
        bus.rs1_addr = 5'd0;
        tick();
        bus.wb_we = 1'b0;
        #1;
        push("wr0.rs1", 0, 32'd0);
        push("wr0.x5",  1, 32'h0000_152F);
        drain();

        // Same-cycle write and read of x4; debug never forwarded.
        bus.wb_we = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'h0000_8000;
        bus.rs1_addr = 5'd4; bus.dbg_addr = 5'd4;
        #1;
        push("byp.rs1", 0, BYP ? 32'h0000_8000 : 32'd0);
        push("byp.dbg", 4, 32'd0);
        push_model("byp"); drain();
        tick();
        bus.wb_we = 1'b0;
        #1;
        push("byp.next", 0, 32'h0000_8000);
        push("byp.dbgn", 4, 32'h0000_8000);
        drain();

        // Issue x7: busy only from the next cycle.
        idle();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.rs2_addr = 5'd7;
        #1; push("iss7.same", 3, 32'd0); drain();
        tick();
        bus.issue_valid = 1'b0;
        #1;
        push("iss7.busy", 3, 32'd1);
        push("iss7.cnt",  5, 32'd1);
        push_model("iss7"); drain();

        // Writeback x7 clears it.
        bus.wb_we = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h0000_7777;
        #1; push("wb7.same", 3, BYP ? 32'd0 : 32'd1); drain();
        tick();
        bus.wb_we = 1'b0;
        #1;
        push("wb7.busy", 3, 32'd0);
        push("wb7.cnt",  5, 32'd0);
        push_model("wb7"); drain();

        // Issue to x0 never pends.
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0; bus.rs1_addr = 5'd0;
        tick();
        bus.issue_valid = 1'b0;
        #1;
        push("iss0.cnt", 5, 32'd0);
        push("iss0.b1",  2, 32'd0);
        drain();

        // Set and clear of x9 in one cycle: set wins, data still updates.
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; bus.rs1_addr = 5'd9;
        tick();
        bus.wb_we = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'hA5A5_0009;
        #1; push("x9.same.b1", 2, 32'd1); push_model("x9.same"); drain();
        tick();
        idle(); bus.rs1_addr = 5'd9;
        #1;
        push("x9.b1",  2, 32'd1);
        push("x9.cnt", 5, 32'd1);
        push("x9.rs1", 0, 32'hA5A5_0009);
        push_model("x9"); drain();

        // Clear of a non-pending register has no effect on the count.
        bus.wb_we = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h0000_005A;
        tick();
        bus.wb_we = 1'b0; bus.rs2_addr = 5'd5;
        #1;
        push("clrnp.cnt", 5, 32'd1);
        push("clrnp.rs2", 1, 32'h0000_005A);
        drain();

        // Issue x3, x6, x10, then asynchronous reset mid-cycle.
        idle();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;  tick();
        bus.issue_rd = 5'd6;  tick();
        bus.issue_rd = 5'd10; tick();
        bus.issue_valid = 1'b0;
        bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd10; bus.dbg_addr = 5'd4;
        #1;
        push("pre.cnt", 5, 32'd4);
        push("pre.b2",  3, 32'd1);
        push_model("pre"); drain();
        bus.wb_we = 1'b1; bus.wb_addr = 5'd12; bus.wb_data = 32'h1234_5678;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd11;
        #1;
        reset = 1'b1;
        #1;
        push("arst.rs1", 0, 32'd0);
        push("arst.b2",  3, 32'd0);
        push("arst.dbg", 4, 32'd0);
        push("arst.cnt", 5, 32'd0);
        drain();
        tick();
        bus.wb_we = 1'b0; bus.issue_valid = 1'b0;
        bus.rs1_addr = 5'd12; bus.rs2_addr = 5'd11;
        #1;
        push("rdom.rs1", 0, 32'd0);
        push("rdom.b2",  3, 32'd0);
        push("rdom.cnt", 5, 32'd0);
        drain();
        @(negedge clk);
        reset = 1'b0;
        tick();
        #1;
        push("post.rs1", 0, 32'd0);
        push_model("post"); drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
